// File: rtl/cordic_range_reduce.sv
// cordic_range_reduce: reduces a signed Q8.16 angle mod 2pi and folds it into [-pi/2, pi/2] with a cosine-negate flag
module cordic_range_reduce #(
  parameter int QINT = 8,
  parameter int QFRAC = 16,
  parameter logic [QINT+QFRAC-1:0] TWO_PI = 'h06487F,
  parameter logic [QINT+QFRAC-1:0] PI = 'h03243F,
  parameter logic [QINT+QFRAC-1:0] HALF_PI = 'h01921F
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic [QINT+QFRAC-1:0] i_theta,
  output logic                  o_rdy,
  output logic                  o_vld,
  output logic [QINT+QFRAC-1:0] o_theta,
  output logic                  o_cos_neg
);
  localparam int W = QINT + QFRAC;
  typedef enum logic [2:0] {IDLE, LOAD, RED, FOLD, DONE} state_t;
  state_t state_q, state_d;
  logic sgn_q, neg_q, neg_d, accept, ge;
  logic [W-1:0] mag_q, theta_q, theta_d;
  logic [W:0] rem_q, sub;
  logic [2:0] k_q;
  logic signed [W+1:0] r, a, pi_s, hpi_s, tpi_s;
  assign accept = i_en & o_rdy;
  assign sub = {1'b0, TWO_PI} << k_q;
  assign ge = rem_q >= sub;
  assign pi_s = $signed({2'b0, PI});
  assign hpi_s = $signed({2'b0, HALF_PI});
  assign tpi_s = $signed({2'b0, TWO_PI});
  always_ff @(posedge i_clk)
    if (i_rst) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: state_d = i_en ? LOAD : IDLE;
      LOAD: state_d = RED;
      RED:  state_d = k_q == 3'd0 ? FOLD : RED;
      FOLD: state_d = DONE;
      DONE: state_d = i_en ? LOAD : IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    o_rdy = state_q == IDLE || state_q == DONE;
    o_vld = state_q == DONE;
  end
  always_comb begin
    r = rem_q > {1'b0, PI} ? $signed({1'b0, rem_q}) - tpi_s : $signed({1'b0, rem_q});
    a = r > hpi_s ? pi_s - r : r < -hpi_s ? -pi_s - r : r;
    neg_d = r > hpi_s || r < -hpi_s;
    theta_d = W'(sgn_q ? -a : a);
  end
  always_ff @(posedge i_clk)
    if (i_rst) begin
      sgn_q <= 1'b0;
      mag_q <= '0;
      rem_q <= '0;
      k_q <= '0;
      theta_q <= '0;
      neg_q <= 1'b0;
    end else begin
      if (accept) begin
        sgn_q <= i_theta[W-1];
        mag_q <= i_theta[W-1] ? -i_theta : i_theta;
      end
      if (state_q == LOAD) begin
        rem_q <= {1'b0, mag_q};
        k_q <= 3'd4;
      end
      if (state_q == RED) begin
        rem_q <= ge ? rem_q - sub : rem_q;
        k_q <= k_q - 3'd1;
      end
      if (state_q == FOLD) begin
        theta_q <= theta_d;
        neg_q <= neg_d;
      end
    end
  assign o_theta = theta_q;
  assign o_cos_neg = neg_q;
endmodule

// File: doc/cordic_range_reduce.md
Name: cordic_range_reduce

Overview:
Upstream angle conditioner for the 16-iteration CORDIC sine/cosine pipeline. The CORDIC core only converges for angles within roughly ±π/2. This block takes any signed Q8.16 angle, reduces it modulo 2π and folds it into [-π/2, π/2]. It emits the reduced angle, which drives the CORDIC i_theta, plus a flag that tells downstream logic to negate the CORDIC cosine result.
It is a multi-cycle iterative unit with a ready/valid-pulse handshake.

Parameters:
QINT, 8, integer bits of the Q format
QFRAC, 16, fractional bits (QBITS = QINT+QFRAC = 24)
TWO_PI, 'h06487F, 2π in Q8.16
PI, 'h03243F, π in Q8.16
HALF_PI, 'h01921F, π/2 in Q8.16

Ports:
i_clk  input  1  clock; all logic on rising edge
i_rst  input  1  synchronous active-high reset
i_en  input  1  request strobe; accepted only when o_rdy=1
i_theta  input  24  signed Q8.16 input angle, full range [-128, 128)
o_rdy  output  1  high when a new request can be accepted
o_vld  output  1  one-cycle pulse: o_theta/o_cos_neg valid
o_theta  output  24  signed Q8.16 reduced angle in [-HALF_PI, HALF_PI]
o_cos_neg  output  1  1 = downstream must negate cosine; sine needs no correction

Behaviour:
- Reset (i_rst=1 at a clock edge, any state, including mid-operation):
  - state→IDLE, o_rdy=1, o_vld=0, o_theta=0, o_cos_neg=0.
  - The in-flight request is discarded; nothing is emitted for it.
- States and transitions:
  - IDLE → LOAD when i_en=1.
  - LOAD → RED (1 cycle).
  - RED runs 5 cycles, k=4..0.
  - RED → FOLD → DONE → IDLE.
- o_rdy=1 in IDLE and DONE only. i_en while o_rdy=0 is ignored: no queuing, no error.
- i_en in DONE is accepted (DONE→LOAD), giving back-to-back throughput of 1 result per 8 cycles.
- Accept edge (IDLE/DONE with i_en=1): latch sgn=i_theta[23] and mag=|i_theta| as a 24-bit unsigned value. -128 ('h800000) gives mag='h800000 with no overflow.
- LOAD: k=4, rem=mag (25-bit unsigned internal).
- RED, one restoring step per cycle: if rem ≥ (TWO_PI<<k) then rem -= TWO_PI<<k; then k--. After k=0, rem ∈ [0, TWO_PI).
- FOLD: if rem > PI then r = rem - TWO_PI, else r = rem. r is signed and lies in (-π, π].
- DONE entry registers the outputs:
  - If r > HALF_PI: a = PI - r, f = 1.
  - Else if r < -HALF_PI: a = -PI - r, f = 1.
  - Else: a = r, f = 0.
  - o_theta = sgn ? -a : a; o_cos_neg = f.
  - o_vld = 1 for exactly the DONE cycle.
- Boundaries:
  - rem == PI is not folded to negative; it then takes the > HALF_PI branch, giving a = 0, f = 1.
  - r == ±HALF_PI is passed through unfolded.
- Latency: accept edge E0 → o_vld high in the cycle following edge E7 (8 cycles).
- Outputs hold their last values after o_vld until the next DONE. They are not cleared on accept.
- Sign identity: cos is even and sin is odd, so negating a for negative inputs is exact. f is independent of sgn.
- All arithmetic is exact integer; there is no rounding beyond the constant values given above.

Test Plan:
- i_theta='h000000 → 8 cycles later o_vld pulse, o_theta='h000000, o_cos_neg=0; o_rdy low for 7 cycles in between.
- i_theta='h020000 (2.0) → o_theta='h01243F, o_cos_neg=1. Then i_theta='hFE0000 (-2.0) → o_theta='hFEDBC1, o_cos_neg=1.
- i_theta='h070000 (7.0) → o_theta='h00B781, o_cos_neg=0. i_theta='h03243F (PI) → o_theta='h000000, o_cos_neg=1.
- Extremes: i_theta='h7FFFFF → o_theta='h00CE2C, o_cos_neg=1. i_theta='h800000 → o_theta='hFF31D5, o_cos_neg=1.
- Handshake:
  - i_en with 'h020000, then i_en with 'h070000 two cycles later → second request ignored; only one o_vld, for 'h020000.
  - i_en in the DONE cycle → accepted; second o_vld exactly 8 cycles after the first.
- Reset: i_en 'h070000, i_rst=1 at the 4th cycle → no o_vld ever appears; o_rdy=1 and o_theta=0 on the next cycle. A following request completes normally.
